// File: rtl/rate_divided_hex_counter.sv
`default_nettype none
// ============================================================================
// Module      : rate_divided_hex_counter
// Description : 4-bit up/down counter advanced by an internal rate divider,
//               feeding the 7-segment hex decoder; emits tick/wrap pulses
//               for chaining further digit stages.
// Revision    : 1.0 - initial release
// ============================================================================
module rate_divided_hex_counter #(
  parameter int CLK_HZ = 50000000,
  parameter int DIV_W  = $clog2(4*CLK_HZ)
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       enable,
  input  logic       up_down,
  input  logic [1:0] speed,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] count,
  output logic       tick,
  output logic       wrap
);

  localparam logic [DIV_W-1:0] c_RELOAD_1X = DIV_W'(CLK_HZ - 1);
  localparam logic [DIV_W-1:0] c_RELOAD_2X = DIV_W'(2*CLK_HZ - 1);
  localparam logic [DIV_W-1:0] c_RELOAD_4X = DIV_W'(4*CLK_HZ - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       count_q, count_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic [1:0]       speed_q;
  logic [DIV_W-1:0] w_reload;
  logic             w_speed_chg;

  // Divider reload value: period of the currently selected speed, minus one
  always_comb begin
    w_reload = '0;
    case (speed)
      2'b00:   w_reload = '0;
      2'b01:   w_reload = c_RELOAD_1X;
      2'b10:   w_reload = c_RELOAD_2X;
      default: w_reload = c_RELOAD_4X;
    endcase
  end

  assign w_speed_chg = (speed != speed_q);

  // Next-state: load beats speed-change reload beats advance beats hold
  always_comb begin
    div_d   = div_q;
    count_d = count_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = load_val;
      div_d   = w_reload;
    end else if (w_speed_chg) begin
      div_d = w_reload;
    end else if (enable) begin
      if (div_q == '0) begin
        div_d  = w_reload;
        tick_d = 1'b1;
        if (up_down) begin
          count_d = count_q + 4'd1;
          wrap_d  = (count_q == 4'hF);
        end else begin
          count_d = count_q - 4'd1;
          wrap_d  = (count_q == 4'h0);
        end
      end else begin
        div_d = div_q - DIV_W'(1);
      end
    end
  end

  // State registers; reset restarts the period for the current speed
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      div_q   <= w_reload;
      count_q <= 4'h0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      speed_q <= speed;
    end else begin
      div_q   <= div_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      speed_q <= speed;
    end
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign wrap  = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_rate_divided_hex_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rate_divided_hex_counter
// Description : Self-checking bench: behavioural reference model plus
//               directed literal checks and randomized stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rate_divided_hex_counter;

  localparam int CLK_HZ = 4;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       enable   = 1'b0;
  logic       up_down  = 1'b1;
  logic [1:0] speed    = 2'b01;
  logic       load     = 1'b0;
  logic [3:0] load_val = 4'h0;
  logic [3:0] count;
  logic       tick;
  logic       wrap;

  int tests  = 0;
  int failed = 0;

  rate_divided_hex_counter #(.CLK_HZ(CLK_HZ)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .enable   (enable),
    .up_down  (up_down),
    .speed    (speed),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tick     (tick),
    .wrap     (wrap)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic int period(input logic [1:0] s);
    case (s)
      2'b00:   return 1;
      2'b01:   return CLK_HZ;
      2'b10:   return 2*CLK_HZ;
      default: return 4*CLK_HZ;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts enabled cycles elapsed in the current period
  int   m_count, m_elapsed;
  bit   m_tick, m_wrap, m_valid;
  logic [1:0] m_speed_prev;

  always @(posedge CLOCK_50) begin
    if (reset) begin
      m_count = 0; m_tick = 0; m_wrap = 0; m_elapsed = 0;
      m_speed_prev = speed; m_valid = 1;
    end else if (m_valid) begin
      m_tick = 0; m_wrap = 0;
      if (load) begin
        m_count = int'(load_val);
        m_elapsed = 0;
      end else if (speed != m_speed_prev) begin
        m_elapsed = 0;
      end else if (enable) begin
        m_elapsed++;
        if (m_elapsed == period(speed)) begin
          m_elapsed = 0;
          m_tick = 1;
          if (up_down) begin
            m_wrap  = (m_count == 15);
            m_count = (m_count + 1) % 16;
          end else begin
            m_wrap  = (m_count == 0);
            m_count = (m_count + 15) % 16;
          end
        end
      end
      m_speed_prev = speed;
    end
  end

  // Compare DUT against model every cycle once the model is initialised
  always @(negedge CLOCK_50) begin
    if (m_valid) begin
      chk("model_count", int'(count), m_count);
      chk("model_tick",  int'(tick),  int'(m_tick));
      chk("model_wrap",  int'(wrap),  int'(m_wrap));
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge CLOCK_50);
  endtask

  initial begin
    // Directed 1: speed 01, up, advances every 4 cycles
    reset = 1; enable = 1; up_down = 1; speed = 2'b01;
    cyc(2);
    chk("reset_count", int'(count), 0);
    chk("reset_tick",  int'(tick),  0);
    reset = 0;
    cyc(3);
    chk("s01_hold_before_first", int'(count), 0);
    cyc(1);
    chk("s01_first_count", int'(count), 1);
    chk("s01_first_tick",  int'(tick),  1);
    cyc(1);
    chk("s01_tick_drop", int'(tick), 0);
    cyc(3);
    chk("s01_second_count", int'(count), 2);

    // Directed 2: speed 00, down from reset wraps immediately
    reset = 1; speed = 2'b00; up_down = 0;
    cyc(1);
    reset = 0;
    cyc(1);
    chk("s00_down_count", int'(count), 15);
    chk("s00_down_wrap",  int'(wrap),  1);
    cyc(1);
    chk("s00_down_count2", int'(count), 14);
    chk("s00_down_tick2",  int'(tick),  1);
    chk("s00_down_wrap2",  int'(wrap),  0);

    // Directed 3: load 0xA during an advance cycle, then count up
    load = 1; load_val = 4'hA; up_down = 1;
    cyc(1);
    load = 0; speed = 2'b01;
    chk("load_count", int'(count), 10);
    chk("load_tick",  int'(tick),  0);
    cyc(1);   // speed-change reload cycle
    cyc(4);
    chk("load_next_count", int'(count), 11);
    chk("load_next_tick",  int'(tick),  1);

    // Directed 4: switch 11 -> 01 mid-count
    reset = 1; speed = 2'b11;
    cyc(1);
    reset = 0;
    cyc(6);
    speed = 2'b01;
    cyc(1);
    chk("switch_no_tick", int'(tick), 0);
    cyc(3);
    chk("switch_wait_count", int'(count), 0);
    cyc(1);
    chk("switch_adv_count", int'(count), 1);
    chk("switch_adv_tick",  int'(tick),  1);

    // Directed 5: reset mid-period with count 7
    load = 1; load_val = 4'h7;
    cyc(1);
    load = 0;
    cyc(2);
    reset = 1;
    cyc(1);
    reset = 0;
    chk("midreset_count", int'(count), 0);
    chk("midreset_wrap",  int'(wrap),  0);

    // Randomized phase, checked by the model
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 99) == 0);
      load     = ($urandom_range(0, 39) == 0);
      load_val = 4'($urandom_range(0, 15));
      enable   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) == 0) up_down = ~up_down;
      if ($urandom_range(0, 29) == 0) speed = 2'($urandom_range(0, 3));
      cyc(1);
    end

    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
